// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bundle.
package alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB = 4'b0001;
    localparam logic [OPW-1:0] OP_MUL = 4'b0010;
    localparam logic [OPW-1:0] OP_DIV = 4'b0011;
    localparam logic [OPW-1:0] OP_AND = 4'b0100;
    localparam logic [OPW-1:0] OP_OR  = 4'b0101;
    localparam logic [OPW-1:0] OP_XOR = 4'b0110;

    // The completion edge leaves EXEC/SHIFT straight to IDLE so that done
    // coincides with IDLE and a new bgn can be taken back-to-back; FIN is
    // kept in the encoding and only ever decodes as a recovery to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic carry;
        logic borrow;
        logic neg;
        logic dvz;
        logic illegal;
    } flags_t;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// WIDTH+1 adder. The start edge already performs the first step, so after
// WIDTH edges (start included) res is final and rdy pulses for one cycle.
//   start  : load a/b/is_div and do step 1
//   res    : MUL -> product, DIV -> {remainder, quotient}
//   rdy    : one-cycle pulse, res valid while high and until next start
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] res,
    output logic               rdy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned SW = WIDTH + 2;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic             div_q, div_d, run_q, run_d, rdy_q, rdy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] hi_c, lo_c, opb_c;
    logic             div_c, ge_c;
    logic [AW-1:0]    add_a_c, add_b_c;
    logic             add_ci_c;
    logic [SW-1:0]    sum_c;

    // Step operands: freshly loaded values on the start edge, registers otherwise.
    always_comb begin
        hi_c  = start ? '0     : hi_q;
        lo_c  = start ? a      : lo_q;
        opb_c = start ? b      : opb_q;
        div_c = start ? is_div : div_q;
    end

    // Shared adder: MUL adds the multiplicand, DIV subtracts the divisor from
    // the shifted partial remainder (carry-out set means no borrow).
    always_comb begin
        if (div_c) begin
            add_a_c  = {hi_c, lo_c[WIDTH-1]};
            add_b_c  = ~{1'b0, opb_c};
            add_ci_c = 1'b1;
        end else begin
            add_a_c  = {1'b0, hi_c};
            add_b_c  = lo_c[0] ? {1'b0, opb_c} : '0;
            add_ci_c = 1'b0;
        end
        sum_c = SW'(add_a_c) + SW'(add_b_c) + SW'(add_ci_c);
        ge_c  = sum_c[SW-1];
    end

    // Next state of the iteration registers and step counter.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        div_d = div_q;
        run_d = run_q;
        cnt_d = cnt_q;
        rdy_d = 1'b0;
        if (start || run_q) begin
            if (div_c) begin
                hi_d = ge_c ? sum_c[WIDTH-1:0] : add_a_c[WIDTH-1:0];
                lo_d = {lo_c[WIDTH-2:0], ge_c};
            end else begin
                hi_d = sum_c[WIDTH:1];
                lo_d = {sum_c[0], lo_c[WIDTH-1:1]};
            end
        end
        if (start) begin
            opb_d = b;
            div_d = is_div;
            run_d = 1'b1;
            cnt_d = CW'(1);
        end else if (run_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_d = 1'b0;
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
            div_q <= div_d;
            run_q <= run_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign res = {hi_q, lo_q};
    assign rdy = rdy_q;

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised multi-cycle ALU with busy/done handshake and optional post-shift.
//   clk, rst (async active-low, deassertion synchronised)
//   bgn/control/sh/pos/nr1/nr2 : request, sampled in IDLE only
//   outbus + flags             : written only at completion, held otherwise
//   busy                       : operation in flight; done : completion pulse
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bgn,
    input  logic [3:0]         control,
    input  logic               sh,
    input  logic [PW-1:0]      pos,
    input  logic [WIDTH-1:0]   nr1,
    input  logic [WIDTH-1:0]   nr2,
    output logic [2*WIDTH-1:0] outbus,
    output logic               carry_next,
    output logic               borrow_next,
    output logic               neg,
    output logic               zero,
    output logic               dvz,
    output logic               illegal,
    output logic               busy,
    output logic               done
);

    localparam int unsigned RW = 2 * WIDTH;

    // Reset: asserts asynchronously, releases two edges after rst rises.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sh_q, sh_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [RW-1:0]    res_q, res_d;
    flags_t           pend_q, pend_d;
    logic [RW-1:0]    outbus_q, outbus_d;
    flags_t           flags_q, flags_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             md_start_c, md_rdy;
    logic [RW-1:0]    md_res;
    logic [WIDTH:0]   add_c;
    logic [WIDTH-1:0] sub_c;
    logic [RW-1:0]    exec_res_c, shift_res_c;
    flags_t           exec_flags_c;
    logic             md_wait_c;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n_int),
        .start  (md_start_c),
        .is_div (control == OP_DIV),
        .a      (nr1),
        .b      (nr2),
        .res    (md_res),
        .rdy    (md_rdy)
    );

    // Result and flags of the latched operation at the end of EXEC.
    always_comb begin
        add_c        = {1'b0, a_q} + {1'b0, b_q};
        sub_c        = a_q - b_q;
        exec_res_c   = '0;
        exec_flags_c = '0;
        md_wait_c    = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
        case (op_q)
            OP_ADD: begin
                exec_res_c         = RW'(add_c);
                exec_flags_c.carry = add_c[WIDTH];
                exec_flags_c.neg   = add_c[WIDTH-1];
            end
            OP_SUB: begin
                exec_res_c          = RW'(sub_c);
                exec_flags_c.borrow = (a_q < b_q);
                exec_flags_c.neg    = sub_c[WIDTH-1];
            end
            OP_MUL: exec_res_c = md_res;
            OP_DIV: begin
                if (b_q == '0) begin
                    exec_res_c       = {a_q, {WIDTH{1'b1}}};
                    exec_flags_c.dvz = 1'b1;
                end else begin
                    exec_res_c = md_res;
                end
            end
            OP_AND:  exec_res_c = RW'(a_q & b_q);
            OP_OR:   exec_res_c = RW'(a_q | b_q);
            OP_XOR:  exec_res_c = RW'(a_q ^ b_q);
            default: exec_flags_c.illegal = 1'b1;
        endcase
        shift_res_c = res_q << pos_q;
    end

    // FSM next-state and output update.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        sh_d       = sh_q;
        pos_d      = pos_q;
        res_d      = res_q;
        pend_d     = pend_q;
        outbus_d   = outbus_q;
        flags_d    = flags_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        md_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bgn) begin
                    op_d       = control;
                    a_d        = nr1;
                    b_d        = nr2;
                    sh_d       = sh;
                    pos_d      = pos;
                    busy_d     = 1'b1;
                    state_d    = ST_EXEC;
                    md_start_c = (control == OP_MUL) ||
                                 ((control == OP_DIV) && (nr2 != '0));
                end
            end
            ST_EXEC: begin
                if (!md_wait_c || md_rdy) begin
                    // Illegal opcodes never take the shift step.
                    if (sh_q && is_legal(op_q)) begin
                        res_d   = exec_res_c;
                        pend_d  = exec_flags_c;
                        state_d = ST_SHIFT;
                    end else begin
                        outbus_d = exec_res_c;
                        flags_d  = exec_flags_c;
                        zero_d   = (exec_res_c == '0);
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_SHIFT: begin
                outbus_d = shift_res_c;
                flags_d  = pend_q;
                zero_d   = (shift_res_c == '0);
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= 1'b0;
            pos_q    <= '0;
            res_q    <= '0;
            pend_q   <= '0;
            outbus_q <= '0;
            flags_q  <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            pos_q    <= pos_d;
            res_q    <= res_d;
            pend_q   <= pend_d;
            outbus_q <= outbus_d;
            flags_q  <= flags_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign outbus      = outbus_q;
    assign carry_next  = flags_q.carry;
    assign borrow_next = flags_q.borrow;
    assign neg         = flags_q.neg;
    assign zero        = zero_q;
    assign dvz         = flags_q.dvz;
    assign illegal     = flags_q.illegal;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=16): expected results are modelled
// at issue time, queued, and compared when done is seen.
module tb_alu_seq_param;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 4;

    localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h1, C_MUL = 4'h2, C_DIV = 4'h3,
                           C_AND = 4'h4, C_OR  = 4'h5, C_XOR = 4'h6;

    logic          clk = 1'b0;
    logic          rst, bgn, sh;
    logic [3:0]    control;
    logic [PW-1:0] pos;
    logic [W-1:0]  nr1, nr2;
    logic [2*W-1:0] outbus;
    logic carry_next, borrow_next, neg, zero, dvz, illegal, busy, done;

    alu_seq_param #(.WIDTH(W), .PW(PW)) dut (
        .clk(clk), .rst(rst), .bgn(bgn), .control(control), .sh(sh), .pos(pos),
        .nr1(nr1), .nr2(nr2), .outbus(outbus), .carry_next(carry_next),
        .borrow_next(borrow_next), .neg(neg), .zero(zero), .dvz(dvz),
        .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        carry, borrow, ng, zr, dz, ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic s, input logic [3:0] p);
        exp_t e;
        logic [16:0] s17;
        logic [15:0] d16;
        e = '{res: 32'h0, carry: 1'b0, borrow: 1'b0, ng: 1'b0, zr: 1'b0, dz: 1'b0, ill: 1'b0, lat: 1};
        case (op)
            C_ADD: begin s17 = {1'b0, a} + {1'b0, b}; e.res = 32'(s17); e.carry = s17[16]; e.ng = s17[15]; end
            C_SUB: begin d16 = a - b; e.res = 32'(d16); e.borrow = (a < b); e.ng = d16[15]; end
            C_MUL: begin e.res = 32'(a) * 32'(b); e.lat = 16; end
            C_DIV: begin
                if (b == 16'h0) begin e.res = {a, 16'hFFFF}; e.dz = 1'b1; end
                else begin e.res = {16'(a % b), 16'(a / b)}; e.lat = 16; end
            end
            C_AND: e.res = 32'(a & b);
            C_OR:  e.res = 32'(a | b);
            C_XOR: e.res = 32'(a ^ b);
            default: e.ill = 1'b1;
        endcase
        if (!e.ill && s) begin
            e.res = e.res << p;
            e.lat = e.lat + 1;
        end
        e.zr = (e.res == 32'h0);
        return e;
    endfunction

    // Issue one op, optionally poke bgn while busy, and score its completion.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [3:0] p, input int poke_at,
                          input logic idle_after, input string tag);
        exp_t e;
        int   edges;
        logic busy_ok;
        sb.push_back(model(op, a, b, s, p));
        @(negedge clk);
        control = op; nr1 = a; nr2 = b; sh = s; pos = p; bgn = 1'b1;
        @(posedge clk); #1;
        bgn = 1'b0;
        check({tag, "_busy0"}, 64'(busy), 64'(1));
        // Operand changes after acceptance must not matter.
        control = 4'(C_XOR); nr1 = 16'($urandom); nr2 = 16'($urandom);
        sh = 1'($urandom); pos = 4'($urandom);
        edges = 0; busy_ok = 1'b1;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            bgn = 1'b0;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (edges == poke_at) begin control = C_ADD; bgn = 1'b1; end
        end
        e = sb.pop_front();
        check({tag, "_lat"},     64'(edges),       64'(e.lat));
        check({tag, "_busywin"}, 64'(busy_ok),     64'(1));
        check({tag, "_busyend"}, 64'(busy),        64'(0));
        check({tag, "_out"},     64'(outbus),      64'(e.res));
        check({tag, "_flags"},
              64'({carry_next, borrow_next, neg, zero, dvz, illegal}),
              64'({e.carry, e.borrow, e.ng, e.zr, e.dz, e.ill}));
        if (idle_after) begin
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_doneclr"}, 64'({busy, done}), 64'(0));
            check({tag, "_hold"},    64'(outbus),       64'(e.res));
        end
    endtask

    initial begin
        rst = 1'b0; bgn = 1'b0; sh = 1'b0; pos = '0; control = '0; nr1 = '0; nr2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 64'(outbus), 64'(0));
        check("reset_flags", 64'({carry_next, borrow_next, neg, zero, dvz, illegal, busy, done}), 64'(0));
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);

        run_op(C_MUL, 16'd15,    16'd3,    1'b1, 4'd1,  0, 1'b1, "mul15x3");
        run_op(C_DIV, 16'd63,    16'd19,   1'b0, 4'd0,  0, 1'b0, "div63_19");
        run_op(C_DIV, 16'h1234,  16'h0,    1'b0, 4'd0,  0, 1'b0, "div0");
        run_op(C_SUB, 16'd3,     16'd15,   1'b0, 4'd0,  0, 1'b0, "sub3_15");
        run_op(C_ADD, 16'hFFFF,  16'h0001, 1'b0, 4'd0,  0, 1'b0, "addcarry");
        run_op(C_ADD, 16'h7FFF,  16'h0003, 1'b0, 4'd0,  0, 1'b0, "addneg");
        run_op(C_AND, 16'h080F,  16'h0603, 1'b0, 4'd0,  0, 1'b0, "and");
        run_op(C_OR,  16'h080F,  16'h0603, 1'b0, 4'd0,  0, 1'b0, "or");
        run_op(C_XOR, 16'h080F,  16'h0603, 1'b0, 4'd0,  0, 1'b1, "xor");
        run_op(4'h9,  16'h1111,  16'h2222, 1'b1, 4'd3,  0, 1'b0, "illegal");
        run_op(C_DIV, 16'h1234,  16'h0,    1'b1, 4'd4,  0, 1'b0, "div0sh");
        run_op(C_SUB, 16'd5,     16'd5,    1'b0, 4'd0,  0, 1'b0, "subzero");
        run_op(C_MUL, 16'hFFFF,  16'hFFFF, 1'b1, 4'd15, 0, 1'b0, "mulmaxsh");
        run_op(C_DIV, 16'hFFFF,  16'h0001, 1'b0, 4'd0,  0, 1'b0, "divby1");
        run_op(C_MUL, 16'd1234,  16'd567,  1'b0, 4'd0,  3, 1'b1, "mulpoke");

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk);
        control = C_MUL; nr1 = 16'd200; nr2 = 16'd300; sh = 1'b0; bgn = 1'b1;
        @(posedge clk); #1 bgn = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("prerst_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("rst_out", 64'(outbus), 64'(0));
        check("rst_flags", 64'({carry_next, borrow_next, neg, zero, dvz, illegal, busy, done}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_idle", 64'({busy, done, outbus}), 64'(0));
        run_op(C_ADD, 16'd2, 16'd2, 1'b0, 4'd0, 0, 1'b1, "add2_2");

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised successor to the team's 16-bit multi-cycle ALU.
- Operand width is generic; MUL and DIV are true iterative datapaths (shift-add and restoring).
- Adds a busy/done handshake, zero, divide-by-zero and illegal-opcode flags, and an optional post-shift stage.
- Sits between the control sequencer (issues bgn and the opcode) and the result bus.

Parameters:
WIDTH, 16, operand width in bits (≥4); result width is 2*WIDTH
PW, $clog2(WIDTH), width of the pos shift amount

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
bgn  in  1  start request, sampled only in IDLE
control  in  4  opcode (alu_pkg)
sh  in  1  enable post-shift of the result by pos
pos  in  PW  left-shift amount for post-shift
nr1  in  WIDTH  operand A, unsigned
nr2  in  WIDTH  operand B, unsigned
outbus  out  2*WIDTH  result, held until the next completion
carry_next  out  1  ADD carry-out
borrow_next  out  1  SUB borrow (nr1 < nr2)
neg  out  1  bit WIDTH-1 of the ADD/SUB result
zero  out  1  outbus == 0
dvz  out  1  DIV with nr2 == 0
illegal  out  1  unused opcode
busy  out  1  operation in flight
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs and flags go to 0 and the FSM goes to IDLE, including mid-operation.
  - Deassertion is synchronised internally, 2 flops.
- Opcodes:
  - 0000 ADD: outbus = zero-extended {carry, sum}.
  - 0001 SUB: outbus = zero-extended WIDTH-bit difference (mod 2^WIDTH).
  - 0010 MUL: unsigned, 2*WIDTH product.
  - 0011 DIV: outbus = {remainder, quotient}.
  - 0100 AND, 0101 OR, 0110 XOR: outbus = zero-extended WIDTH-bit result.
  - 0111-1111: illegal.
- FSM states: IDLE, EXEC, SHIFT, FIN.
- Edge 0: bgn=1 in IDLE.
  - Latches control, nr1, nr2, sh and pos.
  - busy goes to 1, count is cleared, state goes to EXEC.
- EXEC timing:
  - ADD/SUB/logic/illegal/DIV-by-zero take 1 edge.
  - MUL and DIV take exactly WIDTH edges, one bit per edge.
- SHIFT: entered only if sh=1, 1 edge. outbus = result << pos, logical over 2*WIDTH bits; bits shifted out are lost.
- Completion edge (FIN):
  - Writes outbus and all flags.
  - busy goes to 0, done goes to 1.
  - The next edge clears done.
- Total latency, bgn edge to done-high edge: L = E + sh, where E = 1 or WIDTH.
- Flags not defined for the current opcode are written 0 at completion. zero is always computed, on the final outbus.
- illegal: outbus = 0, illegal = 1, latency 1 (no shift).
- dvz:
  - Quotient is all ones and remainder = nr1.
  - Latency 1 + sh; the shift still applies.
- bgn handling:
  - bgn while busy is ignored; no queueing.
  - bgn in the done cycle (state IDLE) is accepted, giving back-to-back operation.
- Operand or control changes after edge 0 have no effect on the operation in flight.
- outbus and flags hold their values while idle and while busy; they change only at completion or reset.

Decomposition:
- alu_pkg:
  - Opcode localparams: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR.
  - FSM state encoding.
- Sub-module seq_muldiv #(WIDTH):
  - Iterative shift-add multiplier and restoring divider sharing one WIDTH+1 adder.
  - Ports: start, is_div, a, b; outputs res[2*WIDTH-1:0] and rdy, pulsed after WIDTH edges.
- The top module holds the FSM, the single-cycle ops, the post-shift and the flags.

Test Plan (WIDTH=16):
- MUL 15*3, sh=1, pos=1 → outbus=0x0000005A, zero=0; done exactly 17 edges after the bgn edge; busy high for edges 1-16 of that window.
- DIV 63/19, sh=0 → outbus=0x00060003, dvz=0; done at edge 16. Then DIV 0x1234/0 → outbus=0x1234FFFF, dvz=1, done at edge 1.
- SUB 3-15 → outbus=0x0000FFF4, borrow_next=1, neg=1. ADD 0xFFFF+1 → outbus=0x00010000, carry_next=1, zero=0. ADD 0x7FFF+3 → outbus=0x00008002, neg=1, carry_next=0.
- nr1=0x080F, nr2=0x0603:
  - AND → 0x00000003.
  - OR → 0x00000E0F.
  - XOR → 0x00000E0C.
  - All complete at edge 1, with carry_next, borrow_next and neg all 0.
- Control 0x9 → illegal=1, outbus=0, done at edge 1. bgn pulsed while busy during a MUL → ignored; the MUL result is unaffected.
- rst low 5 edges into a MUL → outbus, flags, busy and done all 0 immediately (asynchronous). Then a new ADD 2+2 → outbus=0x00000004 with done at edge 1.
